// File: rtl/uart_pkg.sv
// Shared UART matrix definitions: action codes, parity modes, 2x4 geometry and
// the cell-walk order common to transmitter and receiver.
package uart_pkg;
  localparam int ROWS = 2;
  localparam int COLS = 4;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [3:0] {
    ACT_NOP      = 4'd0,
    ACT_CLEAR    = 4'd1,
    ACT_ARM_CELL = 4'd2,
    ACT_ARM_ROW  = 4'd3,
    ACT_ARM_COL  = 4'd4,
    ACT_ARM_ALL  = 4'd5,
    ACT_ABORT    = 4'd6
  } action_e;

  typedef enum logic [1:0] {WALK_CELL, WALK_ROW, WALK_COL, WALK_ALL} walk_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARMED, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_e;

  typedef struct packed {
    logic       last;
    logic       row;
    logic [1:0] col;
  } cell_pos_t;

  // Column-first, then row; 'last' flags that the current cell ends the walk.
  function automatic cell_pos_t walk_next(walk_e mode, logic row, logic [1:0] col);
    cell_pos_t n;
    n.last = 1'b0;
    n.row  = row;
    n.col  = col;
    case (mode)
      WALK_CELL: n.last = 1'b1;
      WALK_ROW:  if (col == 2'(COLS - 1)) n.last = 1'b1; else n.col = col + 2'd1;
      WALK_COL:  if (row == 1'(ROWS - 1)) n.last = 1'b1; else n.row = 1'b1;
      WALK_ALL: begin
        if (col != 2'(COLS - 1)) begin
          n.col = col + 2'd1;
        end else if (row == 1'(ROWS - 1)) begin
          n.last = 1'b1;
        end else begin
          n.row = 1'b1;
          n.col = 2'd0;
        end
      end
      default:   n.last = 1'b1;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/uart_matrix_receiver_if.sv
// Software-facing control/readback bundle of the matrix receiver.
interface uart_matrix_receiver_if #(parameter int W = 8);
  logic         row_i;
  logic [1:0]   col_i;
  logic [3:0]   action_i;
  logic [W-1:0] r_cell_o;
  logic         busy_o;
  logic         done_o;
  logic         perr_o;
  logic         ferr_o;

  modport master (output row_i, col_i, action_i,
                  input  r_cell_o, busy_o, done_o, perr_o, ferr_o);
  modport slave  (input  row_i, col_i, action_i,
                  output r_cell_o, busy_o, done_o, perr_o, ferr_o);
endinterface

// File: rtl/uart_bit_sampler.sv
// Two-flop rx synchroniser plus modulo-DIV bit counter; sample_en marks mid-bit.
// restart holds the counter at zero so the first sample lands DIV/2 cycles after it drops.
module uart_bit_sampler #(
  parameter int DIV = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  input  logic restart_i,
  output logic rxs_o,
  output logic sample_en_o
);
  localparam int CW = $clog2(DIV);

  logic          rx1_q, rxs_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || cnt_q == CW'(DIV - 1)) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx1_q <= 1'b1;
      rxs_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      rx1_q <= rx_i;
      rxs_q <= rx1_q;
      cnt_q <= cnt_d;
    end
  end

  assign rxs_o       = rxs_q;
  assign sample_en_o = (cnt_q == CW'(DIV / 2));
endmodule

// File: rtl/uart_matrix_receiver.sv
// Deserialises one UART frame into the armed cells of a 2x4 matrix of W-bit cells.
// Cells land the cycle after their last bit; done/busy-fall the cycle after the stop sample.
module uart_matrix_receiver
  import uart_pkg::*;
#(
  parameter int W   = 8,
  parameter int DIV = 3,
  parameter int PAR = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  uart_matrix_receiver_if.slave bus
);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  state_e        state_q, state_d;
  walk_e         mode_q, mode_d;
  logic          row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [BW-1:0] bitn_q, bitn_d;
  logic [W-1:0]  sr_q, sr_d;
  logic          par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, done_q, done_d;
  logic          wr_en, clr_en, restart, rxs, sample_en, exp_par;
  cell_pos_t     nxt;
  logic [W-1:0]  mat_q [ROWS][COLS];

  uart_bit_sampler #(.DIV(DIV)) u_smp (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .restart_i   (restart),
    .rxs_o       (rxs),
    .sample_en_o (sample_en)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    row_d   = row_q;
    col_d   = col_q;
    bitn_d  = bitn_q;
    sr_d    = sr_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    restart = 1'b0;
    nxt     = walk_next(mode_q, row_q, col_q);
    exp_par = (PAR == PAR_ODD) ? ~par_q : par_q;
    case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        if (bus.action_i == ACT_CLEAR) clr_en = 1'b1;
        if (bus.action_i >= ACT_ARM_CELL && bus.action_i <= ACT_ARM_ALL) begin
          state_d = ST_ARMED;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          par_d   = 1'b0;
          bitn_d  = '0;
          row_d   = bus.row_i;
          col_d   = bus.col_i;
          mode_d  = WALK_CELL;
          if (bus.action_i == ACT_ARM_ROW) begin
            mode_d = WALK_ROW;
            col_d  = 2'd0;
          end
          if (bus.action_i == ACT_ARM_COL) begin
            mode_d = WALK_COL;
            row_d  = 1'b0;
          end
          if (bus.action_i == ACT_ARM_ALL) begin
            mode_d = WALK_ALL;
            row_d  = 1'b0;
            col_d  = 2'd0;
          end
        end
      end
      ST_ARMED: begin
        if (rxs) restart = 1'b1;
        else     state_d = ST_START;
      end
      ST_START: begin
        if (sample_en) begin
          // A high start-bit sample is line noise: rearm the counter and keep waiting.
          if (rxs) begin
            state_d = ST_ARMED;
            restart = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (sample_en) begin
          sr_d  = {rxs, sr_q[W-1:1]};
          par_d = par_q ^ rxs;
          if (bitn_q == BW'(W - 1)) begin
            bitn_d = '0;
            wr_en  = 1'b1;
            if (nxt.last) begin
              state_d = (PAR != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              row_d = nxt.row;
              col_d = nxt.col;
            end
          end else begin
            bitn_d = bitn_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (sample_en) begin
          if (rxs != exp_par) perr_d = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_en) begin
          if (!rxs) ferr_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && bus.action_i == ACT_ABORT) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= WALK_CELL;
      row_q   <= 1'b0;
      col_q   <= 2'd0;
      bitn_q  <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mat_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bitn_q  <= bitn_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      if (clr_en) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) mat_q[r][c] <= '0;
      end else if (wr_en) begin
        mat_q[row_q][col_q] <= sr_d;
      end
    end
  end

  assign bus.r_cell_o = mat_q[bus.row_i][bus.col_i];
  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.done_o   = done_q;
  assign bus.perr_o   = perr_q;
  assign bus.ferr_o   = ferr_q;
endmodule
